weight_settler: RTL

- Conditioning stage upstream of the object sorter.
- Takes raw load-cell samples, suppresses bounce and noise, and presents a settled weight.
- The settled weight moves only after a run of consecutive in-tolerance samples, and it returns cleanly to 0 when the platform empties.
- The downstream sorter relies on this clean "0 → weight → 0" behaviour to detect new objects.

---
 rtl/weight_settler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/weight_settler.sv
// Load-cell conditioning: debounces raw samples into a settled weight that moves only after
// N consecutive in-tolerance samples, with a clean return to 0 when the platform empties.
module weight_settler #(
  parameter int unsigned W         = 12,
  parameter int unsigned LOG2_N    = 2,
  parameter int unsigned TOL       = 8,
  parameter int unsigned EMPTY_THR = 5,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] raw_weight,
  output logic [W-1:0] weight,
  output logic         changed,
  output logic         settling,
  output logic         unstable
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = W + LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {StStable, StSettling} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    weight_q, weight_d;
  logic [W-1:0]    cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            changed_q, changed_d;
  logic            unstable_q, unstable_d;

  logic [W-1:0]    q;
  logic [CW-1:0]   cnt_n;
  logic [SW-1:0]   sum_n;
  logic [SW-1:0]   avg_full;
  logic [W-1:0]    avg;
  logic [TW-1:0]   tcnt_n;

  // Signed W+1-bit difference so full-scale deviations never wrap.
  function automatic logic in_tol(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return $unsigned(d) <= (W+1)'(TOL);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StStable;
      weight_q   <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tcnt_q     <= '0;
      changed_q  <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      weight_q   <= weight_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      tcnt_q     <= tcnt_d;
      changed_q  <= changed_d;
      unstable_q <= unstable_d;
    end
  end

  always_comb begin
    q        = (raw_weight < W'(EMPTY_THR)) ? '0 : raw_weight;
    tcnt_n   = (tcnt_q == TW'(TIMEOUT)) ? tcnt_q : tcnt_q + 1'b1;
    if (in_tol(q, cand_q)) begin
      cnt_n = cnt_q + 1'b1;
      sum_n = sum_q + SW'(q);
    end else begin
      cnt_n = CW'(1);
      sum_n = SW'(q);
    end
    avg_full = sum_n >> LOG2_N;
    avg      = (avg_full[W-1:0] < W'(EMPTY_THR)) ? '0 : avg_full[W-1:0];

    state_d    = state_q;
    weight_d   = weight_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    tcnt_d     = tcnt_q;
    changed_d  = 1'b0;
    unstable_d = unstable_q;

    if (sample_valid) begin
      unique case (state_q)
        StStable: begin
          if (!in_tol(q, weight_q)) begin
            state_d = StSettling;
            cand_d  = q;
            cnt_d   = CW'(1);
            sum_d   = SW'(q);
            tcnt_d  = TW'(1);
          end
        end
        StSettling: begin
          if (!in_tol(q, cand_q)) cand_d = q;
          if (cnt_n == CW'(N)) begin
            state_d    = StStable;
            weight_d   = avg;
            changed_d  = (avg != weight_q);
            cnt_d      = '0;
            sum_d      = '0;
            tcnt_d     = '0;
            unstable_d = 1'b0;
          end else begin
            cnt_d  = cnt_n;
            sum_d  = sum_n;
            tcnt_d = tcnt_n;
            if (tcnt_n == TW'(TIMEOUT)) unstable_d = 1'b1;
          end
        end
        default: state_d = StStable;
      endcase
    end
  end

  always_comb begin
    weight   = weight_q;
    changed  = changed_q;
    settling = (state_q == StSettling);
    unstable = unstable_q;
  end

endmodule
